// File: rtl/crash_detect_pkg.sv
// Shared game constants and the crash controller state encoding.
// Sprite sizes are reused by the enemy mover and the renderer.
package crash_detect_pkg;

  localparam logic [11:0] SPAWN_X  = 12'd1180;
  localparam logic [11:0] SCREEN_W = 12'd1280;
  localparam logic [11:0] SCREEN_H = 12'd720;

  localparam logic [11:0] PLAYER_W_DEF = 12'd60;
  localparam logic [11:0] PLAYER_H_DEF = 12'd40;
  localparam logic [11:0] ENEMY_W_DEF  = 12'd50;
  localparam logic [11:0] ENEMY_H_DEF  = 12'd40;

  typedef enum logic [1:0] {
    StPlay  = 2'd0,
    StHit   = 2'd1,
    StRearm = 2'd2,
    StOver  = 2'd3
  } state_e;

  // True when edge a lies strictly left of (b + size); 13-bit sum so nothing wraps.
  function automatic logic edge_lt(input logic [11:0] a, input logic [11:0] b,
                                   input logic [11:0] size);
    return {1'b0, a} < ({1'b0, b} + {1'b0, size});
  endfunction

endpackage

// File: rtl/crash_detect_box_overlap.sv
// box_overlap: registered axis-aligned box overlap test.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   a_x, a_y           top-left of box A (size A_W x A_H)
//   b_x, b_y           top-left of box B (size B_W x B_H)
//   overlap            registered result, one cycle after the positions
// Touching edges do not count as overlap.
module box_overlap
  import crash_detect_pkg::*;
#(
  parameter logic [11:0] A_W = PLAYER_W_DEF,
  parameter logic [11:0] A_H = PLAYER_H_DEF,
  parameter logic [11:0] B_W = ENEMY_W_DEF,
  parameter logic [11:0] B_H = ENEMY_H_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] a_x,
  input  logic [11:0] a_y,
  input  logic [11:0] b_x,
  input  logic [11:0] b_y,
  output logic        overlap
);

  logic overlap_d;
  logic overlap_q;

  assign overlap_d = edge_lt(a_x, b_x, B_W) & edge_lt(b_x, a_x, A_W) &
                     edge_lt(a_y, b_y, B_H) & edge_lt(b_y, a_y, A_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overlap_q <= 1'b0;
    else     overlap_q <= overlap_d;
  end

  assign overlap = overlap_q;

endmodule

// File: rtl/crash_detect.sv
// crash_detect: player/enemy collision controller feeding the enemy mover.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   player_x, player_y   player box top-left
//   enemy_x, enemy_y     enemy box top-left (from enemy mover)
//   restart              one-cycle pulse, only acted on in game over
//   CRASH                high during the hit hold window and in game over
//   hit_pulse            one-cycle strobe per accepted hit
//   lives                remaining lives
//   game_over            high while latched in game over
module crash_detect
  import crash_detect_pkg::*;
#(
  parameter logic [11:0] PLAYER_W    = PLAYER_W_DEF,
  parameter logic [11:0] PLAYER_H    = PLAYER_H_DEF,
  parameter logic [11:0] ENEMY_W     = ENEMY_W_DEF,
  parameter logic [11:0] ENEMY_H     = ENEMY_H_DEF,
  parameter logic [31:0] HOLD_CYCLES = 32'd1000000,
  parameter logic [2:0]  LIVES_INIT  = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic [11:0] enemy_x,
  input  logic [11:0] enemy_y,
  input  logic        restart,
  output logic        CRASH,
  output logic        hit_pulse,
  output logic [2:0]  lives,
  output logic        game_over
);

  // Stage 1: position registers.
  logic [11:0] px_q, py_q, ex_q, ey_q;
  // Pipeline fill tracker: overlap_q only reflects real inputs once both stages have loaded,
  // so REARM cannot mistake reset-zero positions for a cleared overlap.
  logic [1:0]  fill_q;
  logic        overlap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q   <= '0;
      py_q   <= '0;
      ex_q   <= '0;
      ey_q   <= '0;
      fill_q <= '0;
    end else begin
      px_q   <= player_x;
      py_q   <= player_y;
      ex_q   <= enemy_x;
      ey_q   <= enemy_y;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Stage 2: registered compare.
  box_overlap #(
    .A_W(PLAYER_W),
    .A_H(PLAYER_H),
    .B_W(ENEMY_W),
    .B_H(ENEMY_H)
  ) u_box_overlap (
    .clk    (clk),
    .rst    (rst),
    .a_x    (px_q),
    .a_y    (py_q),
    .b_x    (ex_q),
    .b_y    (ey_q),
    .overlap(overlap_q)
  );

  state_e      state_q, state_d;
  logic        crash_q, crash_d;
  logic        hit_q, hit_d;
  logic [2:0]  lives_q, lives_d;
  logic        over_q, over_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRearm;
      crash_q <= 1'b0;
      hit_q   <= 1'b0;
      lives_q <= LIVES_INIT;
      over_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crash_q <= crash_d;
      hit_q   <= hit_d;
      lives_q <= lives_d;
      over_q  <= over_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    crash_d = crash_q;
    hit_d   = 1'b0;
    lives_d = lives_q;
    over_d  = over_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StPlay: begin
        if (overlap_q) begin
          state_d = StHit;
          hit_d   = 1'b1;
          lives_d = lives_q - 3'd1;
          crash_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StHit: begin
        crash_d = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        if (cnt_q == HOLD_CYCLES - 32'd1) begin
          if (lives_q == 3'd0) begin
            state_d = StOver;
            over_d  = 1'b1;
          end else begin
            state_d = StRearm;
            crash_d = 1'b0;
          end
        end
      end
      StRearm: begin
        crash_d = 1'b0;
        if (fill_q[1] && !overlap_q) state_d = StPlay;
      end
      StOver: begin
        crash_d = 1'b1;
        over_d  = 1'b1;
        if (restart) begin
          state_d = StRearm;
          lives_d = LIVES_INIT;
          over_d  = 1'b0;
          crash_d = 1'b0;
        end
      end
      default: state_d = StRearm;
    endcase
  end

  assign CRASH     = crash_q;
  assign hit_pulse = hit_q;
  assign lives     = lives_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_crash_detect.sv
// Scoreboard bench for crash_detect: stimulus pushes expected hit strobes and CRASH
// falling edges into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_crash_detect;
  import crash_detect_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] player_x, player_y, enemy_x, enemy_y;
  logic        restart;
  logic        crash, hit_pulse, game_over;
  logic [2:0]  lives;

  crash_detect #(
    .HOLD_CYCLES(32'd16),
    .LIVES_INIT (3'd3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .player_x (player_x),
    .player_y (player_y),
    .enemy_x  (enemy_x),
    .enemy_y  (enemy_y),
    .restart  (restart),
    .CRASH    (crash),
    .hit_pulse(hit_pulse),
    .lives    (lives),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int lives;
  } hit_t;

  hit_t hit_q[$];
  int   fall_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs change only on posedge or rst, so negedge sampling is race-free.
  hit_t h;
  logic prev_crash = 1'b0;
  always @(negedge clk) begin
    if (hit_pulse) begin
      if (hit_q.size() == 0) begin
        check("unexpected_hit", int'(hit_pulse), 0);
      end else begin
        h = hit_q.pop_front();
        check("hit_cycle", cyc, h.cyc);
        check("hit_lives", int'(lives), h.lives);
      end
    end
    if (prev_crash && !crash) begin
      if (fall_q.size() == 0) check("unexpected_crash_fall", int'(crash), 1);
      else check("crash_fall_cycle", cyc, fall_q.pop_front());
    end
    prev_crash = crash;
  end

  // Inputs change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_pos(input int ex, input int ey);
    player_x = 12'd100;
    player_y = 12'd300;
    enemy_x  = 12'(ex);
    enemy_y  = 12'(ey);
  endtask

  // Inputs at cycle k: stage 1 at k+1, overlap_q at k+2, hit strobe at k+3,
  // CRASH held 16 cycles so it falls at k+19.
  task automatic do_hit(input int ex, input int ey, input int lives_after);
    hit_t e;
    set_pos(ex, ey);
    e.cyc   = cyc + 3;
    e.lives = lives_after;
    hit_q.push_back(e);
    if (lives_after != 0) fall_q.push_back(cyc + 19);
    step(3);
    set_pos(1180, 350);
    step(20);
  endtask

  initial begin
    hit_t e;
    rst     = 1'b1;
    restart = 1'b0;
    set_pos(1180, 350);
    step(2);
    check("rst_crash", int'(crash), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_game_over", int'(game_over), 0);
    check("rst_hit_pulse", int'(hit_pulse), 0);
    check("rst_state", int'(dut.state_q), int'(StRearm));

    // Far apart: pipeline fills, then PLAY; no hits for 100 cycles.
    rst = 1'b0;
    step(3);
    check("far_state_play", int'(dut.state_q), int'(StPlay));
    step(100);
    check("far_crash", int'(crash), 0);
    check("far_lives", int'(lives), 3);

    // Overlap held through the hold window: one hit only, then parked in REARM.
    set_pos(140, 320);
    e.cyc   = cyc + 3;
    e.lives = 2;
    hit_q.push_back(e);
    fall_q.push_back(cyc + 19);
    step(30);
    check("held_state_rearm", int'(dut.state_q), int'(StRearm));
    check("held_lives", int'(lives), 2);
    check("held_crash", int'(crash), 0);
    set_pos(1180, 350);
    step(4);
    check("cleared_state_play", int'(dut.state_q), int'(StPlay));

    // Touching edge (100+60 == 160) is not a hit; 159 is.
    set_pos(160, 320);
    step(10);
    check("touch_lives", int'(lives), 2);
    check("touch_state", int'(dut.state_q), int'(StPlay));
    do_hit(159, 320, 1);

    // Restart outside game over is ignored.
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(2);
    check("restart_play_lives", int'(lives), 1);
    check("restart_play_state", int'(dut.state_q), int'(StPlay));

    // Last life: game over latches with CRASH held.
    do_hit(140, 320, 0);
    check("over_game_over", int'(game_over), 1);
    check("over_crash", int'(crash), 1);
    check("over_lives", int'(lives), 0);
    step(5);
    check("over_still_crash", int'(crash), 1);
    check("over_state", int'(dut.state_q), int'(StOver));

    fall_q.push_back(cyc + 1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_lives", int'(lives), 3);
    check("restart_game_over", int'(game_over), 0);
    check("restart_crash", int'(crash), 0);
    step(3);

    // Reset in the middle of a hold: immediate, then no hit while overlap persists.
    set_pos(140, 320);
    e.cyc   = cyc + 3;
    e.lives = 2;
    hit_q.push_back(e);
    step(8);
    check("midhit_crash_before", int'(crash), 1);
    fall_q.push_back(cyc);
    rst = 1'b1;
    #1;
    check("midhit_rst_crash", int'(crash), 0);
    check("midhit_rst_lives", int'(lives), 3);
    step(3);
    rst = 1'b0;
    step(10);
    check("post_rst_state", int'(dut.state_q), int'(StRearm));
    check("post_rst_lives", int'(lives), 3);
    set_pos(1180, 350);
    step(4);
    check("post_rst_play", int'(dut.state_q), int'(StPlay));
    do_hit(140, 320, 2);

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 50 && (hit_q.size() != 0 || fall_q.size() != 0); i++) step(1);
    check("hits_outstanding", hit_q.size(), 0);
    check("falls_outstanding", fall_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
